// File: rtl/flit_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// flit_pipe_arbiter
//
// Round-robin arbiter that feeds single flits into an external fixed-latency
// shift pipeline (DEPTH register stages). A shadow valid/id chain runs
// alongside the external pipeline. When a flit reaches the pipeline output,
// the chain marks it as valid and tags it with its requester. Each requester
// may have at most MAX_INFLIGHT flits inside the pipeline. Once it reaches
// that limit it is masked from arbitration until one of its flits retires.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-requester request, held with its data until granted
//   req_data   per-requester flit, requester i on bits [i*W +: W]
//   gnt        one-hot grant (combinational), zero or one bit set
//   pipe_in    registered flit driven into the pipeline's data_in
//   pipe_out   the pipeline's data_out
//   out_valid  registered; the flit on out_data is a real transfer
//   out_id     registered; requester index of the flit on out_data
//   out_data   pipe_out while out_valid=1, else 0
// ---------------------------------------------------------------------------
module flit_pipe_arbiter #(
  parameter int N_REQ        = 4,
  parameter int W            = 4,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       pipe_in,
  input  logic [W-1:0]       pipe_out,
  output logic               out_valid,
  output logic [IDW-1:0]     out_id,
  output logic [W-1:0]       out_data
);

  logic [IDW-1:0]              ptr;
  logic [IDW-1:0]              gnt_idx;
  logic [IDW-1:0]              cand;
  logic                        found;
  logic                        xfer;
  logic [N_REQ-1:0]            full;
  logic [N_REQ-1:0]            retire;
  logic [N_REQ-1:0][CW-1:0]    cnt;
  logic [DEPTH:0]              sh_valid;
  logic [DEPTH:0][IDW-1:0]     sh_id;

  // The mask uses the registered count only. A flit that retires in this
  // same cycle does not free a slot until the next cycle.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that leave it unassigned infer a latch.
    full   = '0;
    retire = '0;
    for (int i = 0; i < N_REQ; i++) begin
      full[i]   = (cnt[i] == CW'(MAX_INFLIGHT));
      retire[i] = out_valid && (out_id == IDW'(i));
    end
  end

  // Round-robin search that starts at ptr. The grant is held at zero while
  // reset is asserted, because req and the counters would otherwise let it
  // through.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(ptr) + 32'(k)) % N_REQ);
      if (!found && req[cand] && !full[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found && rst) gnt[gnt_idx] = 1'b1;
  end

  assign xfer = |gnt;

  // Stage 0 of the shadow chain lines up with pipe_in. Stage DEPTH lines up
  // with pipe_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow chain and counters are small flops, not a memory.
      // They must be cleared so that flits in flight at reset never appear
      // as valid on the output.
      ptr      <= '0;
      pipe_in  <= '0;
      sh_valid <= '0;
      sh_id    <= '0;
      cnt      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments. Every stage then
      // samples the previous value and the chain shifts by one per clock.
      sh_valid <= {sh_valid[DEPTH-1:0], xfer};
      sh_id    <= {sh_id[DEPTH-1:0], gnt_idx};
      if (xfer) begin
        ptr     <= IDW'((32'(gnt_idx) + 32'd1) % N_REQ);
        pipe_in <= req_data[gnt_idx*W +: W];
      end else begin
        pipe_in <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && !retire[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (retire[i] && !gnt[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  assign out_valid = sh_valid[DEPTH];
  assign out_id    = sh_id[DEPTH];
  assign out_data  = out_valid ? pipe_out : '0;

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_chk
    a_cnt_range : assert property (@(posedge clk) disable iff (!rst)
      (cnt[g] <= CW'(MAX_INFLIGHT)) &&
      !(gnt[g] && !retire[g] && full[g]) &&
      !(retire[g] && !gnt[g] && (cnt[g] == '0)));
  end

endmodule
